// File: rtl/bcd_score_counter.sv
// Multi-digit packed-BCD score counter with session high score and boundary flag.
// Latency: score updates on the edge after a rising point strobe; best/new_best follow one cycle later.
// No backpressure: every rising edge of in_i is counted unless clear_i is high in the same cycle.
module bcd_score_counter #(
    parameter int NUM_DIGITS = 3,
    parameter int SATURATE   = 0,
    parameter int INC_STEP   = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    in_i,
    input  logic                    clear_i,
    output logic [4*NUM_DIGITS-1:0] hex_o,
    output logic [4*NUM_DIGITS-1:0] best_o,
    output logic                    overflow_o,
    output logic                    new_best_o
);

    localparam int              W     = 4 * NUM_DIGITS;
    localparam logic [4:0]      STEP5 = 5'(INC_STEP);
    localparam logic [W-1:0]    ALL9  = {NUM_DIGITS{4'h9}};

    logic         in_q;
    logic [W-1:0] hex_q, hex_d;
    logic [W-1:0] best_q, best_d;
    logic         ovf_q, ovf_d;
    logic         nb_q, nb_d;

    logic         inc;
    logic [W-1:0] sum;
    logic         carry_out;

    assign inc = in_i & ~in_q;

    // BCD add of INC_STEP into digit 0 with a ripple carry through the upper digits.
    always_comb begin
        logic [4:0] dsum;
        logic       c;
        sum  = '0;
        dsum = '0;
        c    = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dsum = {1'b0, hex_q[4*i +: 4]} + ((i == 0) ? STEP5 : 5'd0) + {4'd0, c};
            if (dsum > 5'd9) begin
                dsum = dsum - 5'd10;
                c    = 1'b1;
            end else begin
                c    = 1'b0;
            end
            sum[4*i +: 4] = dsum[3:0];
        end
        carry_out = c;
    end

    // Next-state: high-score compare on the registered score, then clear/increment of the score.
    always_comb begin
        hex_d  = hex_q;
        best_d = best_q;
        ovf_d  = 1'b0;
        nb_d   = nb_q;
        // Packed BCD orders the same as unsigned binary, so a plain compare suffices.
        if (hex_q > best_q) begin
            best_d = hex_q;
            nb_d   = 1'b1;
        end
        if (clear_i) begin
            hex_d = '0;
            nb_d  = 1'b0;
        end else if (inc) begin
            ovf_d = carry_out;
            hex_d = (carry_out && (SATURATE != 0)) ? ALL9 : sum;
        end
    end

    // State registers; edge-detect flop resets low so a strobe held through reset counts once.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            in_q   <= 1'b0;
            hex_q  <= '0;
            best_q <= '0;
            ovf_q  <= 1'b0;
            nb_q   <= 1'b0;
        end else begin
            in_q   <= in_i;
            hex_q  <= hex_d;
            best_q <= best_d;
            ovf_q  <= ovf_d;
            nb_q   <= nb_d;
        end
    end

    assign hex_o      = hex_q;
    assign best_o     = best_q;
    assign overflow_o = ovf_q;
    assign new_best_o = nb_q;

endmodule

// File: tb/tb_bcd_score_counter.sv
module tb_bcd_score_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       in0, clr0, in1, clr1;
    logic [7:0] hex0, best0, hex1, best1;
    logic       ovf0, nb0, ovf1, nb1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Wrapping counter, step 1.
    bcd_score_counter #(.NUM_DIGITS(2), .SATURATE(0), .INC_STEP(1)) dut0 (
        .clk_i(clk), .reset_i(reset), .in_i(in0), .clear_i(clr0),
        .hex_o(hex0), .best_o(best0), .overflow_o(ovf0), .new_best_o(nb0)
    );

    // Saturating counter, step 3.
    bcd_score_counter #(.NUM_DIGITS(2), .SATURATE(1), .INC_STEP(3)) dut1 (
        .clk_i(clk), .reset_i(reset), .in_i(in1), .clear_i(clr1),
        .hex_o(hex1), .best_o(best1), .overflow_o(ovf1), .new_best_o(nb1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse0();
        in0 = 1'b1; tick();
        in0 = 1'b0; tick();
    endtask

    task automatic pulse1();
        in1 = 1'b1; tick();
        in1 = 1'b0; tick();
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    logic [7:0] exp12 [12];

    initial begin
        exp12 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                  8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 8'h12};
        reset = 1'b1;
        in0 = 1'b1; clr0 = 1'b0; in1 = 1'b0; clr1 = 1'b0;
        #1;
        chk("rst_hex0", hex0, 8'h00);
        chk("rst_best0", best0, 8'h00);
        chk("rst_ovf0", {7'd0, ovf0}, 8'h00);
        chk("rst_nb0", {7'd0, nb0}, 8'h00);
        chk("rst_hex1", hex1, 8'h00);
        tick(); tick();
        chk("rst_held_hex0", hex0, 8'h00);
        reset = 1'b0;

        // Level held high for 5 cycles counts once.
        tick();
        chk("held_hex_c1", hex0, 8'h01);
        chk("held_best_lag", best0, 8'h00);
        tick();
        chk("held_best", best0, 8'h01);
        chk("held_nb", {7'd0, nb0}, 8'h01);
        tick(); tick(); tick();
        chk("held_hex_c5", hex0, 8'h01);
        in0 = 1'b0;
        tick();

        // Clear keeps best, drops new_best.
        clr0 = 1'b1; tick(); clr0 = 1'b0;
        chk("clr_hex", hex0, 8'h00);
        chk("clr_nb", {7'd0, nb0}, 8'h00);
        chk("clr_best", best0, 8'h01);

        // Twelve isolated pulses across the first decimal carry.
        for (int k = 0; k < 12; k++) begin
            pulse0();
            chk("step_hex", hex0, exp12[k]);
        end
        chk("step_best", best0, 8'h12);
        chk("step_nb", {7'd0, nb0}, 8'h01);

        // Run up to 99, then wrap.
        for (int k = 13; k <= 99; k++) pulse0();
        chk("pre_wrap_hex", hex0, 8'h99);
        chk("pre_wrap_ovf", {7'd0, ovf0}, 8'h00);
        chk("pre_wrap_best", best0, 8'h99);
        in0 = 1'b1; tick();
        chk("wrap_hex", hex0, 8'h00);
        chk("wrap_ovf", {7'd0, ovf0}, 8'h01);
        in0 = 1'b0; tick();
        chk("wrap_ovf_end", {7'd0, ovf0}, 8'h00);
        chk("wrap_best_hold", best0, 8'h99);
        tick();
        chk("wrap_best_hold2", best0, 8'h99);

        // Saturating, step 3: 0x03, 0x06, ..., 0x96, 0x99.
        for (int k = 1; k <= 33; k++) begin
            pulse1();
            chk("sat_step_hex", hex1, to_bcd(3 * k));
        end
        chk("sat_at99_ovf", {7'd0, ovf1}, 8'h00);
        for (int r = 0; r < 2; r++) begin
            in1 = 1'b1; tick();
            chk("sat_hex", hex1, 8'h99);
            chk("sat_ovf", {7'd0, ovf1}, 8'h01);
            in1 = 1'b0; tick();
            chk("sat_ovf_end", {7'd0, ovf1}, 8'h00);
            chk("sat_best", best1, 8'h99);
        end

        // Fresh start, reach 0x42 with best 0x42.
        reset = 1'b1; #1; reset = 1'b0;
        chk("rst2_best0", best0, 8'h00);
        for (int k = 0; k < 42; k++) pulse0();
        chk("p42_hex", hex0, 8'h42);
        chk("p42_best", best0, 8'h42);
        chk("p42_nb", {7'd0, nb0}, 8'h01);

        // Clear and rising edge together: clear wins; held level does not count afterwards.
        clr0 = 1'b1; in0 = 1'b1; tick();
        chk("clrinc_hex", hex0, 8'h00);
        chk("clrinc_nb", {7'd0, nb0}, 8'h00);
        chk("clrinc_best", best0, 8'h42);
        clr0 = 1'b0; tick();
        chk("clrinc_nocount", hex0, 8'h00);
        chk("clrinc_nb2", {7'd0, nb0}, 8'h00);
        in0 = 1'b0; tick();

        // Reach 0x37, then reset between edges.
        for (int k = 0; k < 37; k++) pulse0();
        chk("p37_hex", hex0, 8'h37);
        chk("p37_best", best0, 8'h42);
        reset = 1'b1; #2;
        chk("async_hex", hex0, 8'h00);
        chk("async_best", best0, 8'h00);
        chk("async_ovf", {7'd0, ovf0}, 8'h00);
        chk("async_nb", {7'd0, nb0}, 8'h00);
        in0 = 1'b1;
        tick(); tick();
        chk("async_held_hex", hex0, 8'h00);
        reset = 1'b0;
        tick();
        chk("rel_hex", hex0, 8'h01);
        tick(); tick();
        chk("rel_hex_once", hex0, 8'h01);
        chk("rel_best", best0, 8'h01);
        in0 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
